sbox_lanes: RTL and testbench

SBOX_LANES -- requirements
Module: sbox_lanes

---
 rtl/sbox_lanes.sv | 151 +++++++++++++++
 tb/tb_sbox_lanes.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lanes.sv
// sbox_lanes
//   Applies the AES SubBytes (imode=0) or InvSubBytes (imode=1) byte
//   substitution to LANES independent byte lanes per transfer. Results
//   go into a 2-entry in-order output buffer with ready/valid handshakes
//   on both sides, which gives one cycle of latency and full throughput.
//
// Ports
//   clk     : rising-edge clock
//   rst     : asynchronous, active-low reset
//   idata   : input bytes, lane i = idata[8i+7:8i]
//   imode   : 0 = forward S-box, 1 = inverse S-box
//   ivalid  : idata/imode valid
//   iready  : buffer can accept a transfer this cycle
//   odata   : substituted bytes (zero while ovalid=0)
//   omode   : imode that produced odata (zero while ovalid=0)
//   ovalid  : odata/omode valid
//   oready  : downstream accepts odata this cycle
//   ocount  : completed output transfers, modulo 2^CNT_W
module sbox_lanes #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*LANES-1:0]   idata,
  input  logic                 imode,
  input  logic                 ivalid,
  output logic                 iready,
  output logic [8*LANES-1:0]   odata,
  output logic                 omode,
  output logic                 ovalid,
  input  logic                 oready,
  output logic [CNT_W-1:0]     ocount
);

  // Buffer entries pack the substituted data above the mode bit.
  localparam int              EW      = 8*LANES + 1;
  localparam logic [7:0]      INV_EXP = 8'hFE;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [EW-1:0]      ent0_q, ent0_d;
  logic [EW-1:0]      ent1_q, ent1_d;
  logic [1:0]         count_q, count_d;
  logic [CNT_W-1:0]   ocount_q, ocount_d;
  logic [8*LANES-1:0] subData;
  logic [EW-1:0]      newEntry;
  logic               push;
  logic               pop;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse in GF(2^8) as x^254; this maps 0 to 0, which is
  // exactly the convention the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 7; k >= 0; k--) begin
      r = gmul(r, r);
      if (INV_EXP[k]) r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sboxFwd(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sboxInv(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  // Per-lane substitution of the incoming word.
  always_comb begin
    subData = '0;
    for (int i = 0; i < LANES; i++) begin
      subData[8*i +: 8] = imode ? sboxInv(idata[8*i +: 8]) : sboxFwd(idata[8*i +: 8]);
    end
  end

  // iready is gated by rst so it stays low throughout reset and rises as
  // soon as reset is released, without depending on ivalid or oready.
  assign iready   = rst && (count_q < 2'd2);
  assign ovalid   = (count_q != 2'd0);
  assign push     = ivalid && iready;
  assign pop      = ovalid && oready;
  assign newEntry = {subData, imode};
  assign odata    = ovalid ? ent0_q[EW-1:1] : '0;
  assign omode    = ovalid ? ent0_q[0] : 1'b0;
  assign ocount   = ocount_q;

  // Next-state for the in-order buffer: a pop shifts the second entry to
  // the head, and a push lands in the first slot left free after that
  // shift, so a simultaneous push and pop at count 1 replaces the head.
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    count_d  = count_q;
    ocount_d = ocount_q;
    if (pop) begin
      ent0_d   = ent1_q;
      ocount_d = ocount_q + CNT_ONE;
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        ent0_d = newEntry;
      end else begin
        ent1_d = newEntry;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer and clears the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      count_q  <= 2'd0;
      ocount_q <= '0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      count_q  <= count_d;
      ocount_q <= ocount_d;
    end
  end

endmodule

// File: tb/tb_sbox_lanes.sv
// tb_sbox_lanes
//   Self-checking bench for sbox_lanes. A default instance (LANES=4,
//   CNT_W=16) is checked against a queue-based model of the output buffer
//   whose S-box tables are generated from the field arithmetic at start-up;
//   a second instance (LANES=1, CNT_W=4) exercises counter wrap.
module tb_sbox_lanes;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] idata;
  logic        imode;
  logic        ivalid;
  logic        iready;
  logic [31:0] odata;
  logic        omode;
  logic        ovalid;
  logic        oready;
  logic [15:0] ocount;

  logic [7:0]  wIdata;
  logic        wImode;
  logic        wIvalid;
  logic        wIready;
  logic [7:0]  wOdata;
  logic        wOmode;
  logic        wOvalid;
  logic        wOready;
  logic [3:0]  wOcount;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] refS   [0:255];
  logic [7:0] refInv [0:255];

  typedef struct packed {
    logic [31:0] data;
    logic        mode;
  } entry_t;

  entry_t      modelQ[$];
  logic [15:0] modelCount;

  typedef struct {
    logic [31:0] data;
    logic        mode;
    logic        valid;
    logic [31:0] expData;
    logic        expMode;
    logic        expValid;
  } vector_t;

  vector_t vecs[6];

  sbox_lanes #(.LANES(4), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .idata  (idata),
    .imode  (imode),
    .ivalid (ivalid),
    .iready (iready),
    .odata  (odata),
    .omode  (omode),
    .ovalid (ovalid),
    .oready (oready),
    .ocount (ocount)
  );

  sbox_lanes #(.LANES(1), .CNT_W(4)) dutW (
    .clk    (clk),
    .rst    (rst),
    .idata  (wIdata),
    .imode  (wImode),
    .ivalid (wIvalid),
    .iready (wIready),
    .odata  (wOdata),
    .omode  (wOmode),
    .ovalid (wOvalid),
    .oready (wOready),
    .ocount (wOcount)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Guard against the run never finishing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Walks the multiplicative group with generator 3 while tracking the
  // inverse via division by 3, then applies the affine map to each inverse.
  task automatic buildTables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      refS[p] = x ^ 8'h63;
    end while (p != 8'h01);
    refS[0] = 8'h63;
    for (int i = 0; i < 256; i++) refInv[refS[i]] = i[7:0];
  endtask

  function automatic logic [31:0] refWord(input logic [31:0] d, input logic m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = m ? refInv[d[8*i +: 8]] : refS[d[8*i +: 8]];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Compares every visible output against the model's buffer contents.
  task automatic checkOutput();
    logic [31:0] expData;
    logic        expMode;
    expData = '0;
    expMode = 1'b0;
    if (modelQ.size() > 0) begin
      expData = modelQ[0].data;
      expMode = modelQ[0].mode;
    end
    check("iready", {63'd0, iready}, {63'd0, modelQ.size() < 2});
    check("ovalid", {63'd0, ovalid}, {63'd0, modelQ.size() > 0});
    check("odata",  {32'd0, odata},  {32'd0, expData});
    check("omode",  {63'd0, omode},  {63'd0, expMode});
    check("ocount", {48'd0, ocount}, {48'd0, modelCount});
  endtask

  // Drives one cycle of stimulus, advances the model across the edge and
  // checks the outputs just after it.
  task automatic applyStimulus(input logic [31:0] d, input logic m, input logic v, input logic r);
    logic   doPush;
    logic   doPop;
    entry_t e;
    idata  = d;
    imode  = m;
    ivalid = v;
    oready = r;
    doPush = v && (modelQ.size() < 2);
    doPop  = (modelQ.size() > 0) && r;
    @(posedge clk);
    #1;
    if (doPop) begin
      void'(modelQ.pop_front());
      modelCount = modelCount + 16'd1;
    end
    if (doPush) begin
      e.data = refWord(d, m);
      e.mode = m;
      modelQ.push_back(e);
    end
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    modelCount = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    logic [15:0] base;
    logic [7:0]  b;

    buildTables();
    modelCount = '0;
    rst     = 1'b0;
    idata   = '0;
    imode   = 1'b0;
    ivalid  = 1'b0;
    oready  = 1'b0;
    wIdata  = '0;
    wImode  = 1'b0;
    wIvalid = 1'b0;
    wOready = 1'b0;

    // Reset state while rst is low.
    #2;
    check("reset iready", {63'd0, iready}, 64'd0);
    check("reset ovalid", {63'd0, ovalid}, 64'd0);
    check("reset odata",  {32'd0, odata},  64'd0);
    check("reset ocount", {48'd0, ocount}, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release iready", {63'd0, iready}, 64'd1);

    // Known-answer vectors, streamed with oready held high.
    vecs[0] = '{32'h561CBB00, 1'b0, 1'b1, 32'hB19CEA63, 1'b0, 1'b1};
    vecs[1] = '{32'h63EAB19C, 1'b1, 1'b1, 32'h00BB561C, 1'b1, 1'b1};
    vecs[2] = '{32'h01FF5310, 1'b0, 1'b1, 32'h7C16EDCA, 1'b0, 1'b1};
    vecs[3] = '{32'h7C16EDCA, 1'b1, 1'b1, 32'h01FF5310, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[5] = '{32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].mode, vecs[i].valid, 1'b1);
      check("vec odata",  {32'd0, odata},  {32'd0, vecs[i].expData});
      check("vec omode",  {63'd0, omode},  {63'd0, vecs[i].expMode});
      check("vec ovalid", {63'd0, ovalid}, {63'd0, vecs[i].expValid});
    end
    check("vec ocount", {48'd0, ocount}, 64'd4);

    // Backpressure: A and B fill the buffer, C waits, then all drain in order.
    base = modelCount;
    applyStimulus(32'h00112233, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h44556677, 1'b1, 1'b1, 1'b0);
    check("bp iready low", {63'd0, iready}, 64'd0);
    applyStimulus(32'h8899AABB, 1'b0, 1'b1, 1'b0);
    check("bp head held", {32'd0, odata}, {32'd0, refWord(32'h00112233, 1'b0)});
    applyStimulus(32'h8899AABB, 1'b0, 1'b1, 1'b1);
    check("bp head B", {32'd0, odata}, {32'd0, refWord(32'h44556677, 1'b1)});
    applyStimulus(32'h8899AABB, 1'b0, 1'b1, 1'b1);
    check("bp head C", {32'd0, odata}, {32'd0, refWord(32'h8899AABB, 1'b0)});
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    check("bp ocount", {48'd0, ocount}, {48'd0, base + 16'd3});

    // Streaming: 256 back-to-back words with alternating mode.
    doReset();
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      applyStimulus({b, b, b, b}, b[0], 1'b1, 1'b1);
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    check("stream ocount", {48'd0, ocount}, 64'd256);

    // Randomized traffic against the model; idata is X when not valid.
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = ($urandom % 4) != 0;
      applyStimulus(v ? 32'($urandom) : 32'hxxxxxxxx, 1'($urandom % 2), v, 1'(($urandom % 3) != 0));
    end

    // Reset mid-operation with a full buffer, away from any clock edge.
    applyStimulus(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    check("pre-reset ovalid", {63'd0, ovalid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async ovalid", {63'd0, ovalid}, 64'd0);
    check("async odata",  {32'd0, odata},  64'd0);
    check("async omode",  {63'd0, omode},  64'd0);
    check("async ocount", {48'd0, ocount}, 64'd0);
    check("async iready", {63'd0, iready}, 64'd0);
    modelQ.delete();
    modelCount = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-reset iready", {63'd0, iready}, 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);

    // Counter wrap on the CNT_W=4 instance: 17 output transfers.
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      b       = i[7:0] + 8'h40;
      wIdata  = b;
      wImode  = 1'b0;
      wIvalid = 1'b1;
      wOready = 1'b1;
      @(posedge clk);
      #1;
      check("wrap odata", {56'd0, wOdata}, {56'd0, refS[b]});
    end
    wIvalid = 1'b0;
    @(posedge clk);
    #1;
    check("wrap ovalid", {63'd0, wOvalid}, 64'd0);
    check("wrap ocount", {60'd0, wOcount}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
